// File: rtl/sa_feeder.sv
// Feeder for the NxN weight-stationary systolic array: loads ROWS weight rows,
// then streams activation vectors with lane i delayed by i cycles.
module sa_feeder #(
    parameter int ROWS   = 4,
    parameter int DATA_W = 4,
    parameter int W_W    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     w_valid,
    output logic                     w_ready,
    input  logic [ROWS*W_W-1:0]      w_data,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [ROWS*DATA_W-1:0]   a_data,
    input  logic                     a_last,
    output logic [ROWS*W_W-1:0]      sa_w_in,
    output logic [ROWS-1:0]          sa_weight_wren,
    output logic [ROWS*DATA_W-1:0]   sa_data_in,
    output logic                     sa_active,
    output logic                     busy,
    output logic                     done
);

    // Handshake: a beat transfers on a rising edge where valid & ready are both
    // high; ready depends only on the FSM state, never on valid.

    typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

    localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;

    state_t        state;
    logic [CW-1:0] wcnt;
    logic [CW-1:0] dcnt;
    logic          w_acc;
    logic          a_acc;

    assign w_ready = (state == IDLE) || (state == LOAD_W);
    assign a_ready = (state == STREAM);
    assign busy    = (state != IDLE);
    assign w_acc   = w_valid & w_ready;
    assign a_acc   = a_valid & a_ready;

    // done is registered off the DONE state, so it lands one cycle after the
    // last lane of the final vector has left the skew lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            wcnt           <= '0;
            dcnt           <= '0;
            done           <= 1'b0;
            sa_w_in        <= '0;
            sa_weight_wren <= '0;
            sa_active      <= 1'b0;
        end else begin
            done           <= (state == DONE);
            sa_w_in        <= w_acc ? w_data : '0;
            sa_weight_wren <= {ROWS{w_acc}};
            sa_active      <= a_acc;
            case (state)
                IDLE: begin
                    if (w_acc) begin
                        wcnt  <= CW'(1);
                        state <= (ROWS == 1) ? STREAM : LOAD_W;
                    end
                end
                LOAD_W: begin
                    if (w_acc) begin
                        if (wcnt == CW'(ROWS - 1)) state <= STREAM;
                        else                       wcnt  <= wcnt + CW'(1);
                    end
                end
                STREAM: begin
                    if (a_acc && a_last) begin
                        dcnt  <= '0;
                        state <= (ROWS == 1) ? DONE : DRAIN;
                    end
                end
                DRAIN: begin
                    if (dcnt == CW'(ROWS - 2)) state <= DONE;
                    else                       dcnt  <= dcnt + CW'(1);
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Lane i: an i-deep shift line followed by the output register. Cycles
    // without an accept shift zeros in, which is how bubbles and drain work.
    for (genvar i = 0; i < ROWS; i++) begin : g_lane
        logic [DATA_W-1:0] lane_in;
        logic [DATA_W-1:0] lane_q;

        assign lane_in = a_acc ? a_data[i*DATA_W +: DATA_W] : '0;
        assign sa_data_in[i*DATA_W +: DATA_W] = lane_q;

        if (i == 0) begin : g_direct
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) lane_q <= '0;
                else        lane_q <= lane_in;
            end
        end else begin : g_skew
            logic [DATA_W-1:0] line [i];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < i; k++) line[k] <= '0;
                    lane_q <= '0;
                end else begin
                    line[0] <= lane_in;
                    for (int k = 1; k < i; k++) line[k] <= line[k-1];
                    lane_q <= line[i-1];
                end
            end
        end
    end

endmodule
